output_arbiter: RTL and testbench

OUTPUT_ARBITER -- requirements
Module: output_arbiter

---
 rtl/noc_params.sv | 7 +
 rtl/rr_picker.sv | 26 ++
 rtl/output_arbiter.sv | 72 +++++++
 tb/tb_output_arbiter.sv | 116 +++++++++++
 4 files changed

// File: rtl/noc_params.sv
// noc_params: shared NoC sizing, port index type and output-arbiter state encoding
package noc_params;
  localparam int PORT_NUM = 5;
  localparam int PORT_W = $clog2(PORT_NUM);
  typedef logic [PORT_W-1:0] port_idx_t;
  typedef enum logic {IDLE, LOCKED} arb_state_t;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: first set request at or after ptr, wrapping, as one-hot and index
module rr_picker #(
  parameter int N = 5,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] onehot,
  output logic [W-1:0] idx
);
  int j;
  // scan offsets from farthest to nearest so the nearest set request wins
  always_comb begin
    onehot = '0;
    idx = '0;
    j = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N;
      if (req[j]) begin
        onehot = '0;
        onehot[j] = 1'b1;
        idx = j[W-1:0];
      end
    end
  end
endmodule

// File: rtl/output_arbiter.sv
// output_arbiter: round-robin packet-locking arbiter for one NoC output port
module output_arbiter
  import noc_params::*;
#(
  parameter int PORT_NUM = noc_params::PORT_NUM
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [PORT_NUM-1:0]         req_i,
  input  logic [PORT_NUM-1:0]         head_i,
  input  logic [PORT_NUM-1:0]         tail_i,
  input  logic                        on_off_i,
  output logic [PORT_NUM-1:0]         grant_o,
  output logic                        valid_o,
  output logic                        locked_o,
  output logic [$clog2(PORT_NUM)-1:0] owner_o,
  output logic                        error_o
);
  localparam int W = $clog2(PORT_NUM);
  arb_state_t state_q, state_d;
  logic [W-1:0] owner_q, owner_d, rr_q, rr_d, pick_idx;
  logic [PORT_NUM-1:0] pick_oh;
  logic err_d;
  rr_picker #(.N(PORT_NUM), .W(W)) u_pick (
    .req(req_i & head_i),
    .ptr(rr_q),
    .onehot(pick_oh),
    .idx(pick_idx)
  );
  // grant decision and next state; reset and backpressure leave everything frozen
  always_comb begin
    grant_o = '0;
    state_d = state_q;
    owner_d = owner_q;
    rr_d = rr_q;
    err_d = 1'b0;
    if (!rst && on_off_i) begin
      if (state_q == IDLE) begin
        if (|pick_oh) begin
          grant_o = pick_oh;
          rr_d = (pick_idx == W'(PORT_NUM - 1)) ? '0 : pick_idx + 1'b1;
          state_d = tail_i[pick_idx] ? IDLE : LOCKED;
          owner_d = tail_i[pick_idx] ? owner_q : pick_idx;
        end else begin
          err_d = |(req_i & ~head_i);
        end
      end else if (req_i[owner_q]) begin
        err_d = head_i[owner_q];
        grant_o[owner_q] = !head_i[owner_q];
        state_d = (!head_i[owner_q] && tail_i[owner_q]) ? IDLE : LOCKED;
        owner_d = (!head_i[owner_q] && tail_i[owner_q]) ? '0 : owner_q;
      end
    end
  end
  // state, owner, pointer and error pulse registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_q <= '0;
      error_o <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q <= rr_d;
      error_o <= err_d;
    end
  end
  assign valid_o = |grant_o;
  assign locked_o = state_q == LOCKED;
  assign owner_o = owner_q;
endmodule

// File: tb/tb_output_arbiter.sv
// tb_output_arbiter: scoreboard bench for output_arbiter against a packet-level model
module tb_output_arbiter;
  localparam int N = 5;
  logic clk = 0;
  logic rst = 1;
  logic [N-1:0] req_i = '0, head_i = '0, tail_i = '0;
  logic on_off_i = 1;
  logic [N-1:0] grant_o;
  logic valid_o, locked_o, error_o;
  logic [2:0] owner_o;
  typedef struct {
    logic [N-1:0] grant;
    bit locked;
    int owner;
    bit err;
  } exp_t;
  exp_t q[$];
  int n_chk = 0, n_fail = 0;
  bit m_locked = 0, m_err = 0;
  int m_owner = 0, m_rr = 0;
  output_arbiter dut (
    .clk(clk), .rst(rst), .req_i(req_i), .head_i(head_i), .tail_i(tail_i),
    .on_off_i(on_off_i), .grant_o(grant_o), .valid_o(valid_o),
    .locked_o(locked_o), .owner_o(owner_o), .error_o(error_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // monitor: each cycle the DUT presents a response, pop and compare it
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("grant", int'(grant_o), int'(e.grant));
      chk("valid", int'(valid_o), int'(e.grant != 0));
      chk("onehot", int'($countones(grant_o) <= 1), 1);
      chk("locked", int'(locked_o), int'(e.locked));
      chk("owner", int'(owner_o), e.owner);
      chk("error", int'(error_o), int'(e.err));
    end
  end
  // drive one cycle of inputs and push the response the packet rules demand
  task automatic step(input bit r, input logic [N-1:0] rq, input logic [N-1:0] hd,
                      input logic [N-1:0] tl, input bit oo);
    exp_t e;
    int w;
    bit nerr;
    @(posedge clk);
    #1;
    rst = r; req_i = rq; head_i = hd; tail_i = tl; on_off_i = oo;
    e.grant = '0; e.locked = m_locked; e.owner = m_owner; e.err = m_err;
    nerr = 0;
    if (r) begin
      m_locked = 0; m_owner = 0; m_rr = 0;
    end else if (oo) begin
      if (!m_locked) begin
        w = -1;
        for (int k = 0; k < N; k++) begin
          int i = (m_rr + k) % N;
          if (w < 0 && rq[i] && hd[i]) w = i;
        end
        if (w >= 0) begin
          e.grant[w] = 1'b1;
          m_rr = (w + 1) % N;
          if (!tl[w]) begin m_locked = 1; m_owner = w; end
        end else if ((rq & ~hd) != 0) nerr = 1;
      end else if (rq[m_owner]) begin
        if (hd[m_owner]) nerr = 1;
        else begin
          e.grant[m_owner] = 1'b1;
          if (tl[m_owner]) begin m_locked = 0; m_owner = 0; end
        end
      end
    end
    m_err = nerr;
    q.push_back(e);
  endtask
  initial begin
    step(1, '1, '1, '1, 1);
    step(1, '1, '1, '0, 1);
    repeat (5) step(0, '1, '1, '1, 1);
    step(0, 5'b00001, 5'b00001, 5'b00001, 1);
    step(1, 0, 0, 0, 1);
    step(0, 5'b00101, 5'b00101, 5'b00000, 1);
    step(0, 5'b00101, 5'b00001, 5'b00000, 1);
    step(0, 5'b00101, 5'b00001, 5'b00100, 1);
    step(0, 5'b00001, 5'b00001, 5'b00001, 1);
    step(0, 5'b00010, 5'b00010, 5'b00000, 1);
    repeat (3) step(0, 5'b00011, 5'b00001, 5'b00000, 0);
    step(0, 5'b00011, 5'b00001, 5'b00010, 1);
    step(0, 5'b01000, 5'b00000, 5'b00000, 1);
    step(0, 0, 0, 0, 1);
    step(0, 5'b00100, 5'b00100, 5'b00000, 1);
    step(0, 5'b00100, 5'b00100, 5'b00000, 1);
    step(1, 5'b00100, 5'b00000, 5'b00100, 1);
    step(0, 0, 0, 0, 1);
    step(0, 5'b01000, 5'b01000, 5'b01000, 1);
    step(0, 5'b10010, 5'b10010, 5'b10010, 1);
    step(0, 5'b10010, 5'b10010, 5'b10010, 1);
    step(0, 5'b11111, 5'b11111, 5'b11111, 0);
    for (int c = 0; c < 3000; c++)
      step($urandom_range(63) == 0, N'($urandom), N'($urandom), N'($urandom & $urandom),
           $urandom_range(3) != 0);
    step(0, 0, 0, 0, 1);
    @(negedge clk);
    @(negedge clk);
    chk("drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
